ntt_core_gf64_bu_dif_stage_seq: RTL and testbench

- Sequences one radix-2 decimation-in-frequency (Gentleman-Sande) NTT stage over an N-point GF64 block held in a dual-read/dual-write RAM.
- Generates butterfly operand pair addresses, drives the RAM reads and the butterfly input-valid, and aligns write-back addresses with butterfly results.
- Sits between the NTT stage controller and the GF64 Gentleman-Sande butterfly unit plus its coefficient RAM.

---
 rtl/ntt_core_gf64_bu_dif_stage_seq_if.sv | 34 +++
 rtl/ntt_core_gf64_bu_dif_stage_seq.sv | 144 ++++++++++++++
 tb/tb_ntt_core_gf64_bu_dif_stage_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ntt_core_gf64_bu_dif_stage_seq_if.sv
// Stage-controller and RAM/butterfly signal bundle for the GF64
// Gentleman-Sande DIF stage sequencer.
interface ntt_core_gf64_bu_dif_stage_seq_if #(
    parameter int N_LOG   = 11,
    parameter int STAGE_W = 4
);
    logic               start;
    logic [STAGE_W-1:0] stage;
    logic               hold;
    logic               busy;
    logic               done;
    logic               err;
    logic               rd_en;
    logic [N_LOG-1:0]   rd_add_a;
    logic [N_LOG-1:0]   rd_add_b;
    logic               bu_in_avail;
    logic               wr_en;
    logic [N_LOG-1:0]   wr_add_a;
    logic [N_LOG-1:0]   wr_add_b;

    modport master (
        output start, stage, hold,
        input  busy, done, err,
        input  rd_en, rd_add_a, rd_add_b, bu_in_avail,
        input  wr_en, wr_add_a, wr_add_b
    );

    modport slave (
        input  start, stage, hold,
        output busy, done, err,
        output rd_en, rd_add_a, rd_add_b, bu_in_avail,
        output wr_en, wr_add_a, wr_add_b
    );
endinterface

// File: rtl/ntt_core_gf64_bu_dif_stage_seq.sv
// Radix-2 DIF NTT stage sequencer: pair address generation, read issue,
// and write-back address alignment with the butterfly pipeline.
module ntt_core_gf64_bu_dif_stage_seq #(
    parameter int N_LOG      = 11,
    parameter int STAGE_W    = 4,
    parameter int RAM_RD_LAT = 1,
    parameter int BU_LATENCY = 2
) (
    input logic clk,
    input logic a_rst_n,
    ntt_core_gf64_bu_dif_stage_seq_if.slave io
);
    localparam int D  = RAM_RD_LAT + BU_LATENCY;
    localparam int CW = $clog2(D + 1) + 1;
    localparam int PW = N_LOG - 1;
    localparam logic [PW-1:0]    C_LAST = '1;
    localparam logic [N_LOG-1:0] MSB    = {1'b1, {(N_LOG-1){1'b0}}};
    localparam logic [N_LOG-1:0] ONE_A  = {{(N_LOG-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    c_q, c_d;
    logic [N_LOG-1:0] hm_q, hm_d;
    logic             err_q, err_d;
    logic [CW-1:0]    fl_q, fl_d;
    logic             rd_en;
    logic             wr_en;
    logic             drained;
    logic [N_LOG-1:0] cx, lo_mask, rd_a, rd_b;

    logic [RAM_RD_LAT-1:0] av_q;
    logic [D-1:0]          vld_q;
    logic [N_LOG-1:0]      pa_q [D];
    logic [N_LOG-1:0]      pb_q [D];

    // Insert a 0 at bit h: bits below the half-span mask stay, the rest shift up.
    always_comb begin
        cx      = {1'b0, c_q};
        lo_mask = hm_q - ONE_A;
        rd_a    = ((cx & ~lo_mask) << 1) | (cx & lo_mask);
        rd_b    = rd_a | hm_q;
    end

    assign wr_en   = vld_q[D-1];
    assign drained = (fl_q == CW'(wr_en));

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        hm_d    = hm_q;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    if (io.stage < STAGE_W'(N_LOG)) begin
                        state_d = S_RUN;
                        c_d     = '0;
                        hm_d    = MSB >> io.stage;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                rd_en = !io.hold;
                if (rd_en) begin
                    if (c_q == C_LAST) state_d = S_DRAIN;
                    else               c_d = c_q + PW'(1);
                end
            end
            S_DRAIN: begin
                if (drained) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        fl_d = fl_q;
        unique case ({rd_en, wr_en})
            2'b10:   fl_d = fl_q + CW'(1);
            2'b01:   fl_d = fl_q - CW'(1);
            default: fl_d = fl_q;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            hm_q    <= '0;
            err_q   <= 1'b0;
            fl_q    <= '0;
            av_q    <= '0;
            vld_q   <= '0;
            for (int i = 0; i < D; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            hm_q    <= hm_d;
            err_q   <= err_d;
            fl_q    <= fl_d;
            av_q    <= RAM_RD_LAT'({av_q, rd_en});
            vld_q   <= D'({vld_q, rd_en});
            if (rd_en) begin
                pa_q[0] <= rd_a;
                pb_q[0] <= rd_b;
            end
            // Addresses only advance with a valid slot so the tail holds the last pair.
            for (int i = 1; i < D; i++) begin
                if (vld_q[i-1]) begin
                    pa_q[i] <= pa_q[i-1];
                    pb_q[i] <= pb_q[i-1];
                end
            end
        end
    end

    assign io.busy        = (state_q != S_IDLE);
    assign io.done        = (state_q == S_DONE);
    assign io.err         = err_q;
    assign io.rd_en       = rd_en;
    assign io.rd_add_a    = rd_a;
    assign io.rd_add_b    = rd_b;
    assign io.bu_in_avail = av_q[RAM_RD_LAT-1];
    assign io.wr_en       = wr_en;
    assign io.wr_add_a    = pa_q[D-1];
    assign io.wr_add_b    = pb_q[D-1];
endmodule

// File: tb/tb_ntt_core_gf64_bu_dif_stage_seq.sv
// Directed bench for the DIF stage sequencer: an N_LOG=3 instance for
// timing/addressing detail and an N_LOG=11 instance for back-to-back stages.
module tb_ntt_core_gf64_bu_dif_stage_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    ntt_core_gf64_bu_dif_stage_seq_if #(.N_LOG(3),  .STAGE_W(4)) b3 ();
    ntt_core_gf64_bu_dif_stage_seq_if #(.N_LOG(11), .STAGE_W(4)) b11 ();

    ntt_core_gf64_bu_dif_stage_seq #(
        .N_LOG(3), .STAGE_W(4), .RAM_RD_LAT(1), .BU_LATENCY(2)
    ) u3 (
        .clk(clk),
        .a_rst_n(rst_n),
        .io(b3)
    );

    ntt_core_gf64_bu_dif_stage_seq #(
        .N_LOG(11), .STAGE_W(4), .RAM_RD_LAT(1), .BU_LATENCY(2)
    ) u11 (
        .clk(clk),
        .a_rst_n(rst_n),
        .io(b11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] m_rd, m_av, m_wr, m_done, m_busy, m_err;
    logic [23:0] rdp, wrp;
    logic [17:0] rst_obs;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 16-cycle window on the N_LOG=3 instance; cycle 0 carries start.
    task automatic run3(input logic [3:0] s, input int hlo, input int hhi,
                        input int xs, input int rc);
        m_rd = '0; m_av = '0; m_wr = '0;
        m_done = '0; m_busy = '0; m_err = '0;
        rdp = '0; wrp = '0; rst_obs = '1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            b3.start = (cyc == 0) || (cyc == xs);
            b3.stage = (cyc == 0) ? s : 4'd7;
            b3.hold  = (cyc >= hlo) && (cyc <= hhi);
            rst_n    = !(rc >= 0 && cyc >= rc && cyc < rc + 2);
            #1;
            m_rd[cyc]   = b3.rd_en;
            m_av[cyc]   = b3.bu_in_avail;
            m_wr[cyc]   = b3.wr_en;
            m_done[cyc] = b3.done;
            m_busy[cyc] = b3.busy;
            m_err[cyc]  = b3.err;
            if (b3.rd_en) rdp = {rdp[17:0], b3.rd_add_a, b3.rd_add_b};
            if (b3.wr_en) wrp = {wrp[17:0], b3.wr_add_a, b3.wr_add_b};
            if (cyc == rc)
                rst_obs = {b3.busy, b3.done, b3.err, b3.rd_en,
                           b3.bu_in_avail, b3.wr_en, b3.rd_add_a,
                           b3.rd_add_b, b3.wr_add_a, b3.wr_add_b};
        end
        b3.start = 1'b0;
        b3.hold  = 1'b0;
    endtask

    int nrd, nwr, ndone, bad_rd, bad_wr;
    int dcyc [2];
    logic prev_done;
    logic [10:0] ea;

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        b3.start = 1'b0;  b3.stage = '0;  b3.hold = 1'b0;
        b11.start = 1'b0; b11.stage = '0; b11.hold = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_n3", {b3.busy, b3.done, b3.err, b3.rd_en,
                         b3.bu_in_avail, b3.wr_en, b3.rd_add_a,
                         b3.rd_add_b, b3.wr_add_a, b3.wr_add_b}, 0);
        chk("reset_n11", {b11.busy, b11.done, b11.err, b11.rd_en,
                          b11.bu_in_avail, b11.wr_en, b11.rd_add_a,
                          b11.rd_add_b, b11.wr_add_a, b11.wr_add_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // s=0, no hold
        run3(4'd0, -1, -1, -1, -1);
        chk("s0_rd",   m_rd,   16'h001E);
        chk("s0_av",   m_av,   16'h003C);
        chk("s0_wr",   m_wr,   16'h00F0);
        chk("s0_done", m_done, 16'h0100);
        chk("s0_busy", m_busy, 16'h01FE);
        chk("s0_err",  m_err,  16'h0000);
        chk("s0_rdp",  rdp, 24'b000100_001101_010110_011111);
        chk("s0_wrp",  wrp, 24'b000100_001101_010110_011111);

        // s=1
        run3(4'd1, -1, -1, -1, -1);
        chk("s1_rd",   m_rd,   16'h001E);
        chk("s1_wr",   m_wr,   16'h00F0);
        chk("s1_done", m_done, 16'h0100);
        chk("s1_rdp",  rdp, 24'b000010_001011_100110_101111);
        chk("s1_wrp",  wrp, 24'b000010_001011_100110_101111);

        // s=2
        run3(4'd2, -1, -1, -1, -1);
        chk("s2_rd",   m_rd,   16'h001E);
        chk("s2_done", m_done, 16'h0100);
        chk("s2_rdp",  rdp, 24'b000001_010011_100101_110111);
        chk("s2_wrp",  wrp, 24'b000001_010011_100101_110111);

        // s=0 with hold in cycles 2-3
        run3(4'd0, 2, 3, -1, -1);
        chk("hold_rd",   m_rd,   16'h0072);
        chk("hold_av",   m_av,   16'h00E4);
        chk("hold_wr",   m_wr,   16'h0390);
        chk("hold_done", m_done, 16'h0400);
        chk("hold_busy", m_busy, 16'h07FE);
        chk("hold_rdp",  rdp, 24'b000100_001101_010110_011111);
        chk("hold_wrp",  wrp, 24'b000100_001101_010110_011111);

        // invalid stage
        run3(4'd3, -1, -1, -1, -1);
        chk("bad_err",  m_err,  16'h0002);
        chk("bad_busy", m_busy, 16'h0000);
        chk("bad_rd",   m_rd,   16'h0000);

        // start during a run is ignored
        run3(4'd0, -1, -1, 3, -1);
        chk("xs_rd",   m_rd,   16'h001E);
        chk("xs_wr",   m_wr,   16'h00F0);
        chk("xs_done", m_done, 16'h0100);
        chk("xs_err",  m_err,  16'h0000);
        chk("xs_rdp",  rdp, 24'b000100_001101_010110_011111);

        // reset at cycle 5 aborts the stage
        run3(4'd0, -1, -1, -1, 5);
        chk("rst_outs", rst_obs, 0);
        chk("rst_wr",   m_wr,   16'h0010);
        chk("rst_done", m_done, 16'h0000);
        chk("rst_busy", m_busy, 16'h001E);

        // fresh stage after reset release
        run3(4'd1, -1, -1, -1, -1);
        chk("post_rd",   m_rd,   16'h001E);
        chk("post_wr",   m_wr,   16'h00F0);
        chk("post_done", m_done, 16'h0100);
        chk("post_wrp",  wrp, 24'b000010_001011_100110_101111);

        // N_LOG=11, s=10, back-to-back stages
        nrd = 0; nwr = 0; ndone = 0; bad_rd = 0; bad_wr = 0;
        dcyc[0] = -1; dcyc[1] = -1;
        prev_done = 1'b0;
        for (int cyc = 0; cyc < 2200; cyc++) begin
            @(negedge clk);
            b11.start = (cyc == 0) || (prev_done && ndone == 1);
            b11.stage = 4'd10;
            b11.hold  = 1'b0;
            #1;
            if (b11.rd_en) begin
                ea = 11'((nrd % 1024) * 2);
                if (b11.rd_add_a !== ea || b11.rd_add_b !== (ea | 11'd1))
                    bad_rd++;
                nrd++;
            end
            if (b11.wr_en) begin
                ea = 11'((nwr % 1024) * 2);
                if (b11.wr_add_a !== ea || b11.wr_add_b !== (ea | 11'd1))
                    bad_wr++;
                nwr++;
            end
            prev_done = b11.done;
            if (b11.done) begin
                if (ndone < 2) dcyc[ndone] = cyc;
                ndone++;
            end
        end
        b11.start = 1'b0;
        chk("n11_rd_count",  nrd,     2048);
        chk("n11_wr_count",  nwr,     2048);
        chk("n11_done_cnt",  ndone,   2);
        chk("n11_done0",     dcyc[0], 1028);
        chk("n11_done1",     dcyc[1], 2057);
        chk("n11_rd_addr",   bad_rd,  0);
        chk("n11_wr_addr",   bad_wr,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
